mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 rdy  in  1  global enable; when low, every register holds its value.
REQ-004 mem_din  in  8  RAM read byte, valid one cycle after its address was driven.
REQ-005 mem_dout  out  8  RAM write byte.
REQ-006 mem_a  out  32  RAM byte address.
REQ-007 mem_wr  out  1  RAM write strobe (1 = write).
REQ-008 io_buffer_full  in  1  UART output buffer full.
REQ-009 if_en  in  1  instruction-fetch request, held high until if_done.
REQ-010 if_pc  in  32  fetch address, word aligned, stable while if_en high.
REQ-011 if_done  out  1  one-cycle pulse: if_data valid.
REQ-012 if_data  out  32  fetched instruction word, little-endian.
REQ-013 lsb_en  in  1  load/store request, held high until lsb_done.
REQ-014 lsb_wr  in  1  1 = store, 0 = load.
REQ-015 lsb_len  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-016 lsb_addr  in  32  byte address.
REQ-017 lsb_w_data  in  32  store data; low bytes are used first.
REQ-018 lsb_done  out  1  one-cycle pulse: access complete.
REQ-019 lsb_r_data  out  32  load data, zero-extended above lsb_len.
REQ-020 rob_clear  in  1  pipeline flush from ROB.

Function
REQ-021 The FSM SHALL have four states: IDLE, FETCH, LOAD, STORE; count k is a 3-bit byte counter and L is the access length in bytes (1/2/4; FETCH = 4).
REQ-022 The IDLE-state arbitration SHALL select lsb_en before if_en, latch the address, length and data, set k=0, and enter LOAD/STORE/FETCH.
REQ-023 Reads (FETCH/LOAD) SHALL drive address+k with mem_wr=0 on k=0..L-1, capture mem_din into byte k-1 on k=1..L, then assert done and data together and return to IDLE; total latency from the accept edge to the done cycle is L+1 cycles.
REQ-024 Stores SHALL drive address+k, mem_dout=byte k and mem_wr=1 on k=0..L-1, with mem_wr=0 and lsb_done pulsed on the following cycle; latency is L cycles.
REQ-025 Address+k SHALL be computed mod 2^32 (wrap at 0xFFFFFFFF).
REQ-026 if_done/lsb_done SHALL each be high for exactly one cycle per request; both SHALL never be high in the same cycle.
REQ-027 The cycle after any done SHALL be IDLE, and the request whose done just fired SHALL NOT be re-accepted in that cycle.
REQ-028 rob_clear in LOAD SHALL abort to IDLE with no lsb_done; in FETCH and STORE it SHALL be ignored, and the access SHALL complete normally.
REQ-029 rob_clear sampled in IDLE SHALL suppress acceptance of a load for that cycle.
REQ-030 mem_wr SHALL be 0 in every cycle outside STORE byte writes.
REQ-031 if_data and lsb_r_data SHALL hold their last value until the next done.

Reset
REQ-032 rst SHALL set state=IDLE, k=0, mem_wr=0, mem_a=0, mem_dout=0, if_done=0, lsb_done=0, if_data=0 and lsb_r_data=0, regardless of rdy.
REQ-033 rst asserted mid-access SHALL abandon the access, with no done pulse afterwards and mem_wr=0 from the next cycle.

Configuration
REQ-034 With macro MEM_CTRL_IO_STALL_EN defined, a STORE whose address[17:16]==2'b11 SHALL hold before each byte write (mem_wr=0, k unchanged) while io_buffer_full=1.
REQ-035 Without MEM_CTRL_IO_STALL_EN, io_buffer_full SHALL be ignored.

Verification
REQ-036 Fetch: RAM[0x100..0x103]=13,05,10,00; if_en=1, if_pc=0x100 -> if_done pulse 5 cycles after accept, if_data=0x00100513.
REQ-037 Simultaneous requests: if_en and lsb_en (load byte 0x200, RAM=0xFF) rise together -> lsb_done first with lsb_r_data=0x000000FF; fetch is accepted on the following IDLE.
REQ-038 Half store: lsb_addr=0xFFFFFFFF, len=01, w_data=0xABCD -> writes CD@0xFFFFFFFF then AB@0x00000000; lsb_done on the 3rd cycle.
REQ-039 Flush: rob_clear during word load k=2 -> IDLE next cycle, no lsb_done; a concurrent fetch still completes with correct data.
REQ-040 IO stall (macro on): byte store to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for 3 cycles, then the write occurs; macro off -> write occurs immediately.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: RAM bus, fetch port and load/store port of mem_ctrl.
interface mem_ctrl_if;
  logic        rdy;
  logic        io_buffer_full;
  logic        rob_clear;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_en;
  logic [31:0] if_pc;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_en;
  logic        lsb_wr;
  logic [1:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_w_data;
  logic        lsb_done;
  logic [31:0] lsb_r_data;
  modport slave (
    input  rdy, io_buffer_full, rob_clear, mem_din, if_en, if_pc,
           lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_w_data,
    output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );
  modport master (
    output rdy, io_buffer_full, rob_clear, mem_din, if_en, if_pc,
           lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_w_data,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM arbiter for instruction fetch and load/store.
// Define MEM_CTRL_IO_STALL_EN to hold stores to address[17:16]==2'b11 while io_buffer_full is set.
module mem_ctrl (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave m
);
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_t;
  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d, len_q, len_d, lsb_l;
  logic [31:0] a_q, a_d, mem_a_q, mem_a_d, if_data_q, if_data_d, lsb_r_data_q, lsb_r_data_d;
  logic [31:0] next_a, word;
  logic [23:0] wd_q, wd_d, buf_q, buf_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d, if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic        stall, acc_lsb, acc_if, last;
`ifdef MEM_CTRL_IO_STALL_EN
  assign stall = m.io_buffer_full && (state_q == IDLE ? m.lsb_addr[17:16] : a_q[17:16]) == 2'b11;
`else
  logic unused_io;
  assign stall = 1'b0;
  assign unused_io = m.io_buffer_full;
`endif
  assign lsb_l   = m.lsb_len == 2'b00 ? 3'd1 : m.lsb_len == 2'b01 ? 3'd2 : 3'd4;
  // a requester whose done is still visible is holding its stale request
  assign acc_lsb = m.lsb_en && !lsb_done_q && !(m.rob_clear && !m.lsb_wr);
  assign acc_if  = m.if_en && !if_done_q;
  assign last    = k_q + 3'd1 == len_q;
  assign next_a  = a_q + 32'(k_q) + 32'd1;
  assign word    = len_q == 3'd4 ? {m.mem_din, buf_q} :
                   len_q == 3'd2 ? {16'd0, m.mem_din, buf_q[23:16]} : {24'd0, m.mem_din};
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    len_d        = len_q;
    a_d          = a_q;
    wd_d         = wd_q;
    buf_d        = buf_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    if_data_d    = if_data_q;
    lsb_r_data_d = lsb_r_data_q;
    case (state_q)
      IDLE: begin
        if (acc_lsb) begin
          state_d    = m.lsb_wr ? STORE : LOAD;
          k_d        = 3'd0;
          len_d      = lsb_l;
          a_d        = m.lsb_addr;
          mem_a_d    = m.lsb_addr;
          wd_d       = m.lsb_w_data[31:8];
          mem_dout_d = m.lsb_w_data[7:0];
          mem_wr_d   = m.lsb_wr && !stall;
        end else if (acc_if) begin
          state_d = FETCH;
          k_d     = 3'd0;
          len_d   = 3'd4;
          a_d     = m.if_pc;
          mem_a_d = m.if_pc;
        end
      end
      FETCH, LOAD: begin
        if (state_q == LOAD && m.rob_clear) begin
          state_d = IDLE;
          k_d     = 3'd0;
        end else begin
          k_d = k_q + 3'd1;
          if (k_q != 3'd0) buf_d = {m.mem_din, buf_q[23:8]};
          if (k_q + 3'd1 < len_q) mem_a_d = next_a;
          if (k_q == len_q) begin
            state_d      = IDLE;
            k_d          = 3'd0;
            if_done_d    = state_q == FETCH;
            lsb_done_d   = state_q == LOAD;
            if_data_d    = state_q == FETCH ? word : if_data_q;
            lsb_r_data_d = state_q == LOAD ? word : lsb_r_data_q;
          end
        end
      end
      default: begin
        // mem_wr_q low in STORE means byte k is still waiting to be written
        if (!mem_wr_q) begin
          mem_wr_d = !stall;
        end else if (last) begin
          state_d    = IDLE;
          k_d        = 3'd0;
          lsb_done_d = 1'b1;
        end else begin
          k_d        = k_q + 3'd1;
          mem_a_d    = next_a;
          wd_d       = {8'd0, wd_q[23:8]};
          mem_dout_d = wd_q[7:0];
          mem_wr_d   = !stall;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= 3'd0;
      len_q        <= 3'd0;
      a_q          <= 32'd0;
      wd_q         <= 24'd0;
      buf_q        <= 24'd0;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= 32'd0;
      lsb_r_data_q <= 32'd0;
    end else if (m.rdy) begin
      state_q      <= state_d;
      k_q          <= k_d;
      len_q        <= len_d;
      a_q          <= a_d;
      wd_q         <= wd_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_r_data_q <= lsb_r_data_d;
    end
  end
  assign m.mem_a      = mem_a_q;
  assign m.mem_dout   = mem_dout_q;
  assign m.mem_wr     = mem_wr_q;
  assign m.if_done    = if_done_q;
  assign m.if_data    = if_data_q;
  assign m.lsb_done   = lsb_done_q;
  assign m.lsb_r_data = lsb_r_data_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl fetch, load, store, flush, reset and IO stall behaviour.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] ram [0:65535];
  logic [31:0] wd;
  mem_ctrl_if b();
  mem_ctrl dut (.clk(clk), .rst(rst), .m(b));
  always #5 clk = ~clk;
  always @(posedge clk) b.mem_din <= ram[b.mem_a[15:0]];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h10; ram[16'h0103] = 8'h00;
    ram[16'h0104] = 8'h93; ram[16'h0105] = 8'h00; ram[16'h0106] = 8'h10; ram[16'h0107] = 8'h00;
    ram[16'h0200] = 8'hFF; ram[16'h0201] = 8'h5A;
    ram[16'h0300] = 8'h44; ram[16'h0301] = 8'h33; ram[16'h0302] = 8'h22; ram[16'h0303] = 8'h11;
    rst = 1'b1; b.rdy = 1'b0; b.io_buffer_full = 1'b0; b.rob_clear = 1'b0;
    b.if_en = 1'b0; b.if_pc = 32'd0; b.lsb_en = 1'b0; b.lsb_wr = 1'b0;
    b.lsb_len = 2'b00; b.lsb_addr = 32'd0; b.lsb_w_data = 32'd0;
    tick(); tick();
    chk("rst_mem_wr", b.mem_wr, 32'd0);
    chk("rst_mem_a", b.mem_a, 32'd0);
    chk("rst_mem_dout", b.mem_dout, 32'd0);
    chk("rst_if_done", b.if_done, 32'd0);
    chk("rst_lsb_done", b.lsb_done, 32'd0);
    chk("rst_if_data", b.if_data, 32'd0);
    chk("rst_lsb_r_data", b.lsb_r_data, 32'd0);
    // fetch word at 0x100, request held through the done cycle
    rst = 1'b0; b.rdy = 1'b1; b.if_en = 1'b1; b.if_pc = 32'h100;
    tick();
    chk("fetch_a0", b.mem_a, 32'h100);
    chk("fetch_wr", b.mem_wr, 32'd0);
    for (int i = 1; i < 5; i++) begin tick(); chk("fetch_wait", b.if_done, 32'd0); end
    tick();
    chk("fetch_done", b.if_done, 32'd1);
    chk("fetch_data", b.if_data, 32'h00100513);
    tick();
    chk("fetch_pulse", b.if_done, 32'd0);
    chk("fetch_hold", b.if_data, 32'h00100513);
    b.if_en = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); chk("fetch_no_reaccept", b.if_done, 32'd0); end
    // simultaneous load byte and fetch: load wins, fetch follows
    b.if_en = 1'b1; b.if_pc = 32'h100;
    b.lsb_en = 1'b1; b.lsb_wr = 1'b0; b.lsb_len = 2'b00; b.lsb_addr = 32'h200;
    tick(); chk("sim_load_a", b.mem_a, 32'h200);
    tick(); chk("sim_wait", b.lsb_done | b.if_done, 32'd0);
    tick();
    chk("sim_lsb_done", b.lsb_done, 32'd1);
    chk("sim_lsb_data", b.lsb_r_data, 32'h000000FF);
    chk("sim_if_quiet", b.if_done, 32'd0);
    tick();
    chk("sim_fetch_acc", b.mem_a, 32'h100);
    chk("sim_lsb_pulse", b.lsb_done, 32'd0);
    b.lsb_en = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); chk("sim_fetch_wait", b.if_done | b.lsb_done, 32'd0); end
    tick();
    chk("sim_fetch_done", b.if_done, 32'd1);
    chk("sim_fetch_data", b.if_data, 32'h00100513);
    b.if_en = 1'b0;
    tick();
    // half store across the address wrap
    b.lsb_en = 1'b1; b.lsb_wr = 1'b1; b.lsb_len = 2'b01;
    b.lsb_addr = 32'hFFFFFFFF; b.lsb_w_data = 32'h0000ABCD;
    tick();
    chk("sh_wr0", b.mem_wr, 32'd1);
    chk("sh_a0", b.mem_a, 32'hFFFFFFFF);
    chk("sh_d0", b.mem_dout, 32'hCD);
    tick();
    chk("sh_wr1", b.mem_wr, 32'd1);
    chk("sh_a1", b.mem_a, 32'h00000000);
    chk("sh_d1", b.mem_dout, 32'hAB);
    chk("sh_early_done", b.lsb_done, 32'd0);
    tick();
    chk("sh_done", b.lsb_done, 32'd1);
    chk("sh_wr_off", b.mem_wr, 32'd0);
    chk("sh_rdata_hold", b.lsb_r_data, 32'h000000FF);
    b.lsb_en = 1'b0;
    tick(); chk("sh_pulse", b.lsb_done, 32'd0);
    // len 11 behaves as a word store
    b.lsb_en = 1'b1; b.lsb_len = 2'b11; b.lsb_addr = 32'h400; b.lsb_w_data = 32'h11223344;
    wd = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sw_wr", b.mem_wr, 32'd1);
      chk("sw_a", b.mem_a, 32'h400 + 32'(i));
      chk("sw_dout", b.mem_dout, 32'(wd[8*i +: 8]));
    end
    tick();
    chk("sw_done", b.lsb_done, 32'd1);
    chk("sw_wr_off", b.mem_wr, 32'd0);
    b.lsb_en = 1'b0;
    tick();
    // flush a word load at k=2 while a fetch waits
    b.if_en = 1'b1; b.if_pc = 32'h104;
    b.lsb_en = 1'b1; b.lsb_wr = 1'b0; b.lsb_len = 2'b10; b.lsb_addr = 32'h300;
    tick(); chk("fl_load_a", b.mem_a, 32'h300);
    tick(); tick();
    b.rob_clear = 1'b1; b.lsb_en = 1'b0;
    tick(); chk("fl_no_done", b.lsb_done, 32'd0);
    b.rob_clear = 1'b0;
    tick(); chk("fl_fetch_acc", b.mem_a, 32'h104);
    for (int i = 0; i < 4; i++) begin tick(); chk("fl_wait", b.if_done | b.lsb_done, 32'd0); end
    tick();
    chk("fl_fetch_done", b.if_done, 32'd1);
    chk("fl_fetch_data", b.if_data, 32'h00100093);
    chk("fl_lsb_quiet", b.lsb_done, 32'd0);
    chk("fl_rdata_hold", b.lsb_r_data, 32'h000000FF);
    b.if_en = 1'b0;
    tick();
    // rob_clear in IDLE blocks a load; then rdy low freezes it
    b.rob_clear = 1'b1; b.lsb_en = 1'b1; b.lsb_wr = 1'b0; b.lsb_len = 2'b00; b.lsb_addr = 32'h201;
    tick(); chk("idle_clear_block", b.mem_a, 32'h107);
    b.rob_clear = 1'b0;
    tick(); chk("ld_acc", b.mem_a, 32'h201);
    b.rdy = 1'b0;
    tick(); tick();
    chk("rdy_hold_a", b.mem_a, 32'h201);
    chk("rdy_hold_done", b.lsb_done, 32'd0);
    b.rdy = 1'b1;
    tick(); chk("ld_wait", b.lsb_done, 32'd0);
    tick();
    chk("ld_done", b.lsb_done, 32'd1);
    chk("ld_data", b.lsb_r_data, 32'h0000005A);
    b.lsb_en = 1'b0;
    tick();
    // byte store to IO region with the UART buffer full
    b.lsb_en = 1'b1; b.lsb_wr = 1'b1; b.lsb_len = 2'b00;
    b.lsb_addr = 32'h30000; b.lsb_w_data = 32'h77; b.io_buffer_full = 1'b1;
`ifdef MEM_CTRL_IO_STALL_EN
    for (int i = 0; i < 3; i++) begin tick(); chk("io_stall_wr", b.mem_wr, 32'd0); end
    b.io_buffer_full = 1'b0;
    tick();
`else
    tick();
`endif
    chk("io_wr", b.mem_wr, 32'd1);
    chk("io_a", b.mem_a, 32'h30000);
    chk("io_dout", b.mem_dout, 32'h77);
    tick();
    chk("io_done", b.lsb_done, 32'd1);
    chk("io_wr_off", b.mem_wr, 32'd0);
    b.lsb_en = 1'b0; b.io_buffer_full = 1'b0;
    tick();
    // reset in the middle of a word store
    b.lsb_en = 1'b1; b.lsb_wr = 1'b1; b.lsb_len = 2'b10;
    b.lsb_addr = 32'h500; b.lsb_w_data = 32'hCAFEF00D;
    tick(); chk("mr_wr", b.mem_wr, 32'd1);
    rst = 1'b1; b.lsb_en = 1'b0;
    tick();
    chk("mr_wr_off", b.mem_wr, 32'd0);
    chk("mr_a", b.mem_a, 32'd0);
    chk("mr_dout", b.mem_dout, 32'd0);
    chk("mr_rdata", b.lsb_r_data, 32'd0);
    chk("mr_if_data", b.if_data, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); chk("mr_quiet", b.lsb_done | b.mem_wr, 32'd0); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
